// File: rtl/mf_pll_sequencer.sv
// Reset/lock sequencer for a multi-output PLL: reset pulse, lock wait with retries, stability check, staggered domain release.
// Latency: pll_locked is seen 2 cycles late through the synchronizer; every output is registered, one cycle after its decision.
// No backpressure: restart_req is a fire-and-forget pulse. The MF_PLL_SEQ_LOSS_CNT_EN macro enables the lock-loss counter.
module mf_pll_sequencer #(
  parameter int NUM_OUT             = 5,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 74250,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 64,
  parameter int MAX_RETRIES         = 7
) (
  input  logic               i_refclk,
  input  logic               i_rst_n,
  input  logic               i_pll_locked,
  input  logic               i_restart_req,
  output logic               o_pll_rst,
  output logic [NUM_OUT-1:0] o_domain_rst_n,
  output logic               o_ready,
  output logic               o_fail,
  output logic [3:0]         o_retry_count,
  output logic [7:0]         o_lock_loss_count
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max_i(max_i(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                              max_i(LOCK_STABLE_CYCLES, STAGGER_CYCLES));
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(NUM_OUT + 1);

  localparam logic [TW-1:0] HOLD_V    = TW'(RST_HOLD_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STAB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] STAG_LAST = TW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] NOUT_V    = IW'(NUM_OUT);
  localparam logic [3:0]    MAX_V     = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t             r_state, w_state;
  logic [TW-1:0]      r_timer, w_timer;
  logic [IW-1:0]      r_idx, w_idx;
  logic [3:0]         r_retry, w_retry, w_retry_inc;
  logic [NUM_OUT-1:0] r_dom, w_dom;
  logic               r_pll_rst, w_pll_rst;
  logic               r_ready, w_ready;
  logic               r_fail, w_fail;
  logic               r_sync1, r_sync2;
  logic               w_lk;

  assign w_lk = r_sync2;

  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_state   <= S_RESET;
      r_timer   <= '0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_dom     <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_idx     <= w_idx;
      r_retry   <= w_retry;
      r_dom     <= w_dom;
      r_pll_rst <= w_pll_rst;
      r_ready   <= w_ready;
      r_fail    <= w_fail;
      r_sync1   <= i_pll_locked;
      r_sync2   <= r_sync1;
    end
  end

  // Timer holds cycles already spent in the state; entering RESET counts the entry cycle,
  // so a retry attempt lasts exactly as long as the attempt after power-on reset.
  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_idx       = r_idx;
    w_retry     = r_retry;
    w_dom       = r_dom;
    w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

    case (r_state)
      S_RESET: begin
        if (r_timer == HOLD_V) begin
          w_state = S_WAIT_LOCK;
          w_timer = '0;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lk) begin
          w_state = S_STABLE;
          w_timer = '0;
        end else if (r_timer == TOUT_LAST) begin
          w_retry = w_retry_inc;
          w_timer = TW'(1);
          w_state = (w_retry_inc == MAX_V) ? S_FAIL : S_RESET;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_lk) begin
          w_state = S_WAIT_LOCK;
          w_timer = '0;
        end else if (r_timer == STAB_LAST) begin
          w_state = S_RELEASE;
          w_timer = '0;
          w_idx   = IW'(1);
          w_dom   = NUM_OUT'(1);
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!w_lk) begin
          w_state = S_RESET;
          w_timer = TW'(1);
        end else if (r_idx == NOUT_V) begin
          w_state = S_RUN;
          w_retry = '0;
        end else if (r_timer == STAG_LAST) begin
          w_dom   = r_dom | (NUM_OUT'(1) << r_idx);
          w_idx   = r_idx + 1'b1;
          w_timer = '0;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lk) begin
          w_state = S_RESET;
          w_timer = TW'(1);
        end
      end
      S_FAIL: begin
        w_state = S_FAIL;
      end
      default: begin
        w_state = S_RESET;
        w_timer = TW'(1);
      end
    endcase

    if (i_restart_req) begin
      w_state = S_RESET;
      w_timer = TW'(1);
      w_retry = '0;
    end

    if (w_state == S_RESET || w_state == S_FAIL) begin
      w_dom = '0;
    end
    w_pll_rst = (w_state == S_RESET) || (w_state == S_FAIL);
    w_ready   = (w_state == S_RUN);
    w_fail    = (w_state == S_FAIL);
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_domain_rst_n = r_dom;
  assign o_ready        = r_ready;
  assign o_fail         = r_fail;
  assign o_retry_count  = r_retry;

`ifdef MF_PLL_SEQ_LOSS_CNT_EN
  logic       w_loss_evt;
  logic [7:0] r_loss;

  // A restart pulse coinciding with the loss still counts the event.
  assign w_loss_evt = (r_state == S_RUN) && !w_lk;

  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_loss <= '0;
    end else if (w_loss_evt && (r_loss != 8'hFF)) begin
      r_loss <= r_loss + 8'd1;
    end
  end

  assign o_lock_loss_count = r_loss;
`else
  assign o_lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_mf_pll_sequencer.sv
// Directed bench for mf_pll_sequencer with small timing parameters; expected cycles are hand-derived.
// Cycle 0 is the first rising edge with rst_n high; outputs are sampled and inputs driven 1 time unit after each edge.
module tb_mf_pll_sequencer;

  localparam int NOUT = 5;
  localparam int HOLD = 4;
  localparam int TOUT = 20;
  localparam int STAB = 8;
  localparam int STAG = 2;
  localparam int MAXR = 3;

`ifdef MF_PLL_SEQ_LOSS_CNT_EN
  localparam logic [7:0] LOSS_EXP = 8'd1;
`else
  localparam logic [7:0] LOSS_EXP = 8'd0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pll_locked;
  logic            restart_req;
  logic            pll_rst;
  logic [NOUT-1:0] domain_rst_n;
  logic            ready;
  logic            fail;
  logic [3:0]      retry_count;
  logic [7:0]      lock_loss_count;

  int cyc;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mf_pll_sequencer #(
    .NUM_OUT             (NOUT),
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TOUT),
    .LOCK_STABLE_CYCLES  (STAB),
    .STAGGER_CYCLES      (STAG),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .i_refclk          (clk),
    .i_rst_n           (rst_n),
    .i_pll_locked      (pll_locked),
    .i_restart_req     (restart_req),
    .o_pll_rst         (pll_rst),
    .o_domain_rst_n    (domain_rst_n),
    .o_ready           (ready),
    .o_fail            (fail),
    .o_retry_count     (retry_count),
    .o_lock_loss_count (lock_loss_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(input logic lk);
    rst_n       = 1'b0;
    pll_locked  = lk;
    restart_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  // Walks the staggered release starting one cycle before domain 0 until ready rises.
  task automatic check_release(input int t_rel);
    logic [NOUT-1:0] exp_d;
    for (int c = t_rel - 1; c <= t_rel + (NOUT - 1) * STAG + 1; c++) begin
      run_to(c);
      exp_d = '0;
      for (int i = 0; i < NOUT; i++) begin
        if (c >= t_rel + i * STAG) exp_d[i] = 1'b1;
      end
      chk("rel_dom_rst_n", 32'(domain_rst_n), 32'(exp_d));
      chk("rel_ready", 32'(ready), 32'(c >= t_rel + (NOUT - 1) * STAG + 1));
      chk("rel_pll_rst", 32'(pll_rst), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc         = 0;
    rst_n       = 1'b0;
    pll_locked  = 1'b1;
    restart_req = 1'b0;

    // Reset state, then locked from cycle 0.
    repeat (3) tick();
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_dom", 32'(domain_rst_n), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);
    chk("rst_loss", 32'(lock_loss_count), 32'd0);
    rst_n = 1'b1;
    cyc   = -1;
    run_to(0);  chk("s1_pll_rst_c0", 32'(pll_rst), 32'd1);
    run_to(3);  chk("s1_pll_rst_c3", 32'(pll_rst), 32'd1);
    run_to(4);  chk("s1_pll_rst_c4", 32'(pll_rst), 32'd0);
    check_release(13);
    chk("s1_retry", 32'(retry_count), 32'd0);

    // Never locks: three timed-out attempts, then sticky FAIL until restart.
    do_reset(1'b0);
    run_to(23); chk("s2_retry_c23", 32'(retry_count), 32'd0);
                chk("s2_pll_rst_c23", 32'(pll_rst), 32'd0);
    run_to(24); chk("s2_retry_c24", 32'(retry_count), 32'd1);
                chk("s2_pll_rst_c24", 32'(pll_rst), 32'd1);
    run_to(71); chk("s2_retry_c71", 32'(retry_count), 32'd2);
                chk("s2_fail_c71", 32'(fail), 32'd0);
    run_to(72); chk("s2_fail_c72", 32'(fail), 32'd1);
                chk("s2_retry_c72", 32'(retry_count), 32'd3);
                chk("s2_pll_rst_c72", 32'(pll_rst), 32'd1);
                chk("s2_ready_c72", 32'(ready), 32'd0);
    run_to(90); chk("s2_fail_sticky", 32'(fail), 32'd1);
                chk("s2_pll_rst_sticky", 32'(pll_rst), 32'd1);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    chk("s2_restart_fail", 32'(fail), 32'd0);
    chk("s2_restart_retry", 32'(retry_count), 32'd0);
    chk("s2_restart_pll_rst", 32'(pll_rst), 32'd1);
    run_to(94);  chk("s2_rehold_c94", 32'(pll_rst), 32'd1);
    run_to(95);  chk("s2_rewait_c95", 32'(pll_rst), 32'd0);
    run_to(115); chk("s2_retry_c115", 32'(retry_count), 32'd1);
                 chk("s2_fail_c115", 32'(fail), 32'd0);

    // One-cycle lock glitch during STABLE restarts the stability count.
    do_reset(1'b1);
    run_to(7);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    run_to(13); chk("s3_no_early_rel", 32'(domain_rst_n), 32'd0);
    check_release(19);
    chk("s3_retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN, then full re-release; restart in RUN keeps the loss count.
    do_reset(1'b1);
    run_to(30); chk("s4_ready_c30", 32'(ready), 32'd1);
    pll_locked = 1'b0;
    run_to(32); chk("s4_ready_c32", 32'(ready), 32'd1);
                chk("s4_dom_c32", 32'(domain_rst_n), 32'h1F);
    run_to(33); chk("s4_ready_c33", 32'(ready), 32'd0);
                chk("s4_dom_c33", 32'(domain_rst_n), 32'd0);
                chk("s4_pll_rst_c33", 32'(pll_rst), 32'd1);
                chk("s4_loss_c33", 32'(lock_loss_count), 32'(LOSS_EXP));
    pll_locked = 1'b1;
    run_to(36); chk("s4_pll_rst_c36", 32'(pll_rst), 32'd1);
    run_to(37); chk("s4_pll_rst_c37", 32'(pll_rst), 32'd0);
    check_release(46);
    run_to(60);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    chk("s4_restart_ready", 32'(ready), 32'd0);
    chk("s4_restart_dom", 32'(domain_rst_n), 32'd0);
    chk("s4_restart_pll_rst", 32'(pll_rst), 32'd1);
    chk("s4_restart_loss", 32'(lock_loss_count), 32'(LOSS_EXP));

    // Synchronous reset mid-RELEASE, then timing restarts from cycle 0.
    do_reset(1'b1);
    run_to(16); chk("s5_dom_c16", 32'(domain_rst_n), 32'h03);
    rst_n = 1'b0;
    tick();
    chk("s5_rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("s5_rst_dom", 32'(domain_rst_n), 32'd0);
    chk("s5_rst_ready", 32'(ready), 32'd0);
    chk("s5_rst_loss", 32'(lock_loss_count), 32'd0);
    rst_n = 1'b1;
    cyc   = -1;
    run_to(3); chk("s5_pll_rst_c3", 32'(pll_rst), 32'd1);
    run_to(4); chk("s5_pll_rst_c4", 32'(pll_rst), 32'd0);
    check_release(13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mf_pll_sequencer.md
Name: mf_pll_sequencer

Overview:
Reset/lock sequencer for the core's multi-output PLL, running on the PLL reference clock. It pulses the PLL reset, waits for lock with a timeout and bounded retries, then qualifies lock stability. It then releases per-output-domain reset requests in a staggered order and watches for lock loss. Downstream per-domain synchronizers (external) consume domain_rst_n.

Parameters:
NUM_OUT, 5, number of PLL output domains / width of domain_rst_n
RST_HOLD_CYCLES, 16, cycles pll_rst held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 74250, max cycles in WAIT_LOCK before retry (1 ms at 74.25 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
STAGGER_CYCLES, 64, gap between successive domain releases (>=1)
MAX_RETRIES, 7, failed attempts allowed before FAIL (1..15)

Ports:
refclk  in  1  reference clock; all logic on this clock
rst_n  in  1  synchronous active-low reset
pll_locked  in  1  PLL locked, asynchronous; 2-flop synchronized internally
restart_req  in  1  single-cycle pulse: restart full sequence
pll_rst  out  1  active-high PLL reset
domain_rst_n  out  NUM_OUT  active-low reset request per output domain
ready  out  1  all domains released, lock held
fail  out  1  retries exhausted
retry_count  out  4  failed attempts in current sequence
lock_loss_count  out  8  lock-loss events in RUN (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at edge): state RESET, counters 0, pll_rst=1, domain_rst_n=all 0, ready=0, fail=0, retry_count=0, lock_loss_count=0, sync flops 0. Overrides everything, mid-sequence included.
- lk = pll_locked after 2 flops; 2-cycle latency. All outputs registered.
- Cycle 0 = first edge with rst_n=1.
- RESET: pll_rst=1, domain_rst_n=0. Stays RST_HOLD_CYCLES cycles, then WAIT_LOCK; pll_rst=0 from that cycle.
- WAIT_LOCK: timer counts. lk=1 -> STABLE, timer cleared. Timer reaching LOCK_TIMEOUT_CYCLES with lk=0 -> retry_count+1. If new value == MAX_RETRIES -> FAIL, else RESET.
- STABLE: counts consecutive lk=1. lk=0 -> WAIT_LOCK (both counters cleared, retry_count unchanged). Count reaching LOCK_STABLE_CYCLES -> RELEASE at cycle T_rel.
- RELEASE: domain_rst_n[i] goes 1 at cycle T_rel + i*STAGGER_CYCLES, in index order, never lowered again within RELEASE. After the last domain is released -> RUN. ready=1 at T_rel+(NUM_OUT-1)*STAGGER_CYCLES+1. retry_count cleared on entry to RUN.
- lk=0 during RELEASE: treated as lock loss -> RESET. domain_rst_n all 0 next cycle.
- RUN: ready=1. lk=0 -> next cycle domain_rst_n all 0, ready=0, pll_rst=1, state RESET, lock_loss_count+1 (saturates at 255).
- FAIL: pll_rst=1, domain_rst_n=0, fail=1, ready=0. Sticky. Exits only via restart_req or rst_n.
- restart_req=1 in any state: next state RESET, retry_count=0, fail=0, domain_rst_n=0, ready=0. lock_loss_count not changed.
- restart_req coincident with lock loss in RUN: a single RESET entry; lock_loss_count still increments.
- retry_count saturates at 15. Counter widths are $clog2(max value + 1).
- Invariant: ready=1 implies domain_rst_n all 1, pll_rst=0, fail=0.

Optional Feature:
MF_PLL_SEQ_LOSS_CNT_EN:
- Defined: lock_loss_count implemented as above, 8-bit saturating, cleared only by rst_n.
- Undefined: lock_loss_count tied to 0 with no counter logic. All other behaviour unchanged.

Test Plan:
All scenarios use NUM_OUT=5, RST_HOLD=4, TIMEOUT=20, STABLE=8, STAGGER=2, MAX_RETRIES=3.
1. pll_locked=1 from cycle 0 -> pll_rst=1 cycles 0-3. domain_rst_n[0..4] rise at cycles 13, 15, 17, 19, 21. ready=1 at cycle 22. retry_count=0.
2. pll_locked=0 always -> three RESET/WAIT_LOCK attempts (24 cycles each). fail=1 and retry_count=3 at cycle 72. pll_rst stays 1. Then restart_req pulse -> fail=0, retry_count=0, new sequence begins.
3. Glitch: pll_locked drops for 1 cycle mid-STABLE -> stable count restarts. Release occurs 8 synced-high cycles after the glitch ends. No retry counted.
4. In RUN, drop pll_locked -> 2 cycles sync latency, then one cycle later ready=0, domain_rst_n=5'b00000, pll_rst=1, lock_loss_count=1. Restore lock -> full staggered re-release.
5. rst_n=0 for 1 cycle during RELEASE (domains 0-1 released) -> all outputs return to reset values next edge. Sequence restarts from cycle 0 timing.
6. Macro undefined: repeat scenario 4 -> lock_loss_count stays 0, all other timing identical.
